mult_iter: RTL
==============

# mult_iter

Parametrised, multi-cycle unsigned/signed multiplier that computes a full 2·WIDTH-bit product by iterating over SLICE-bit limb pairs through a single shared SLICE×SLICE multiplier. It replaces fixed 32-bit staged multipliers in the DSP datapath (filter and envelope scaling). Operands enter and results leave over valid/ready handshakes, so the block can sit between pipeline stages that stall.

## Interface
- WIDTH, 32, operand width in bits; must be a multiple of SLICE.
- SLICE, 16, limb width in bits and the width of the shared multiplier.
- K (localparam), WIDTH/SLICE, limbs per operand; K ≥ 1.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept operands.
- dataa  in  WIDTH  multiplicand.
- datab  in  WIDTH  multiplier.
- sign  in  1  1 = two's-complement operands, 0 = unsigned; sampled with operands.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  2·WIDTH  product.

## Operation
- States: IDLE → MUL → FIX → DONE → IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch operands, sign flag, clear accumulator, pair index p=0, go to MUL.
- Signed accept: each operand replaced by its magnitude (unsigned, WIDTH bits; 2^(WIDTH-1) for the most-negative value); neg = sign(dataa) XOR sign(datab).
- MUL: each cycle, i=p mod K, j=p div K; acc += (a_limb[i]·b_limb[j]) << (SLICE·(i+j)); all arithmetic unsigned, acc 2·WIDTH bits, no overflow possible. After p=K·K−1, go to FIX.
- FIX: result ← neg ? −acc (two's complement, 2·WIDTH bits) : acc; go to DONE.
- DONE: out_valid=1, result held stable; on out_ready, go to IDLE.
- in_ready only in IDLE; no accept in DONE even if out_ready is high.
- in_valid while not ready is ignored; operand inputs are don't-care outside the accept cycle.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, acc=0.
- Latency: accept edge to out_valid high = K·K+1 cycles (WIDTH=32, SLICE=16: 5 cycles; K=1: 2 cycles). Constant, independent of sign and of the macro.
- Throughput: one result per K·K+3 cycles with out_ready tied high (accept, K·K MUL, FIX, DONE, IDLE).
- Output handshake completes on the edge where out_valid&&out_ready; out_valid drops the next cycle.
- out_ready low: DONE held indefinitely, result unchanged.
- Reset at any state: operation aborts; no out_valid for the aborted transaction; reset wins over a simultaneous in_valid.
- Shared multiplier inputs are zero outside MUL.

## Configuration
- MULT_ITER_SIGNED_EN defined: sign input honoured as above.
- Not defined: sign is ignored; magnitude conversion and FIX negation are removed, and all transactions are unsigned. The FIX state still exists, so latency is unchanged.

## Structure
- Package mult_pkg: state enum (IDLE, MUL, FIX, DONE) and a function computing the pair-counter width from K.
- Sub-module mult_slice: combinational SLICE×SLICE unsigned multiplier, 2·SLICE-bit output. Exactly one instance.
- Elaboration check: error if WIDTH % SLICE ≠ 0.

## Test plan
- Unsigned, WIDTH=32: 0xFFFFFFFF × 0xFFFFFFFF, sign=0 → result 0xFFFFFFFE00000001, out_valid exactly 5 cycles after the accept edge.
- Signed (macro on): 0xFFFFFFFD × 0x00000005, sign=1 → 0xFFFFFFFFFFFFFFF1. 0x80000000 × 0x80000000, sign=1 → 0x4000000000000000.
- Macro off: 0xFFFFFFFF × 0xFFFFFFFF, sign=1 → 0xFFFFFFFE00000001.
- Backpressure: out_ready low for 10 cycles after out_valid → result stable and in_ready=0 throughout; accepted on the first out_ready cycle.
- Reset during MUL (cycle 2 after accept) → next cycle in IDLE with out_valid=0; a new 3 × 7 transaction → 21.
- WIDTH=64, SLICE=16 (K=4), random operands with out_ready always high → match the reference model with latency 17 and 10,000 back-to-back transactions.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types for the iterative multiplier: FSM state encoding and pair-counter sizing.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Width needed to index K*K limb pairs; never less than one bit.
    function automatic int pair_cnt_w(input int k);
        return (k * k > 1) ? $clog2(k * k) : 1;
    endfunction

endpackage

// File: rtl/mult_slice.sv
// Combinational unsigned SLICE x SLICE multiplier shared by every limb pair.
module mult_slice #(
    parameter int SLICE = 16
) (
    input  logic [SLICE-1:0]   a,
    input  logic [SLICE-1:0]   b,
    output logic [2*SLICE-1:0] prod
);

    assign prod = {{SLICE{1'b0}}, a} * {{SLICE{1'b0}}, b};

endmodule

// File: rtl/mult_iter.sv
// Multi-cycle WIDTH x WIDTH multiplier iterating limb pairs through one shared slice multiplier.
// Define MULT_ITER_SIGNED_EN to honour the sign input (two's-complement operands).
module mult_iter
    import mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   dataa,
    input  logic [WIDTH-1:0]   datab,
    input  logic               sign,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result
);

    localparam int K  = WIDTH / SLICE;
    localparam int W2 = 2 * WIDTH;
    localparam int PW = pair_cnt_w(K);
    localparam logic [PW-1:0] P_LAST = PW'(K * K - 1);

    generate
        if ((WIDTH % SLICE) != 0 || K < 1) begin : g_bad_cfg
            $error("mult_iter: WIDTH must be a non-zero multiple of SLICE");
        end
    endgenerate

    state_t             state, next_state;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [W2-1:0]      acc;
    logic [W2-1:0]      res_reg;
    logic [PW-1:0]      pair;
    logic               mul_en;
    logic [SLICE-1:0]   mul_a, mul_b;
    logic [2*SLICE-1:0] prod;
    logic [W2-1:0]      prod_shifted;
    int                 li, lj;

`ifdef MULT_ITER_SIGNED_EN
    logic neg;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [W2-1:0] apply_sign(input logic [W2-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction
`else
    logic unused_sign;
    assign unused_sign = sign;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (in_valid)       next_state = MUL;
            MUL:  if (pair == P_LAST) next_state = FIX;
            FIX:                      next_state = DONE;
            DONE: if (out_ready)      next_state = IDLE;
            default:                  next_state = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mul_en    = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            MUL:     mul_en    = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Limb selection: pair p walks a-limbs fastest (i = p mod K, j = p div K)
    always_comb begin
        li    = int'(pair) % K;
        lj    = int'(pair) / K;
        mul_a = mul_en ? SLICE'(a_reg >> (SLICE * li)) : '0;
        mul_b = mul_en ? SLICE'(b_reg >> (SLICE * lj)) : '0;
        prod_shifted = W2'(prod) << (SLICE * (li + lj));
    end

    mult_slice #(.SLICE(SLICE)) u_slice (
        .a    (mul_a),
        .b    (mul_b),
        .prod (prod)
    );

    // Datapath: operand capture, accumulation, final sign fix-up
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            pair    <= '0;
            res_reg <= '0;
`ifdef MULT_ITER_SIGNED_EN
            neg     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
`ifdef MULT_ITER_SIGNED_EN
                        a_reg <= magnitude(dataa, sign);
                        b_reg <= magnitude(datab, sign);
                        neg   <= sign & (dataa[WIDTH-1] ^ datab[WIDTH-1]);
`else
                        a_reg <= dataa;
                        b_reg <= datab;
`endif
                        acc   <= '0;
                        pair  <= '0;
                    end
                end
                MUL: begin
                    acc  <= acc + prod_shifted;
                    pair <= pair + 1'b1;
                end
                FIX: begin
`ifdef MULT_ITER_SIGNED_EN
                    res_reg <= apply_sign(acc, neg);
`else
                    res_reg <= acc;
`endif
                end
                default: ;
            endcase
        end
    end

    assign result = res_reg;

endmodule
